// File: rtl/sr_button_conditioner.sv
// Button front end for an SR NOR latch: synchronise, debounce, edge-detect and
// sequence two raw buttons into fixed-width, never-overlapping S/R pulses.
module sr_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_CYCLES    = 2,
  parameter int RESET_PRIORITY  = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_btn,
  input  logic reset_btn,
  output logic S,
  output logic R,
  output logic q_track,
  output logic busy,
  output logic conflict
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = $clog2(PULSE_CYCLES + 1);
  localparam bit R_WINS = (RESET_PRIORITY != 0);

  typedef enum logic [1:0] {
    IDLE,
    PULSE_S,
    PULSE_R,
    GAP
  } state_e;

  // Channel index 0 is set, index 1 is reset.
  logic [1:0]    meta_q, sync_q, db_q, db_d, db_dly_q, req;
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];

  state_e        state_q;
  logic [PW-1:0] pcnt_q;
  logic [1:0]    pend_q;
  logic          s_q, r_q, q_q, busy_q, conflict_q;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      // NOTE: every path starts from the held value, so no latch can be inferred.
      cnt_d[i] = cnt_q[i];
      db_d[i]  = db_q[i];
      if (sync_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
        db_d[i]  = sync_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Only a debounced press (0->1) requests a pulse; releases are ignored.
  assign req = db_q & ~db_dly_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q   <= '0;
      sync_q   <= '0;
      db_q     <= '0;
      db_dly_q <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      // NOTE: non-blocking so each stage samples its predecessor's pre-edge value.
      meta_q   <= {reset_btn, set_btn};
      sync_q   <= meta_q;
      db_q     <= db_d;
      db_dly_q <= db_q;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pcnt_q     <= '0;
      pend_q     <= '0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      q_q        <= 1'b0;
      busy_q     <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      conflict_q <= 1'b0;
      pend_q     <= pend_q | req;
      case (state_q)
        IDLE: begin
          if (pend_q != 2'b00) begin
            // Both flags are consumed here (winner served, loser dropped);
            // a press landing on this very edge stays queued.
            pend_q     <= req;
            pcnt_q     <= '0;
            busy_q     <= 1'b1;
            conflict_q <= &pend_q;
            if (pend_q[1] && (!pend_q[0] || R_WINS)) begin
              state_q <= PULSE_R;
              r_q     <= 1'b1;
              q_q     <= 1'b0;
            end else begin
              state_q <= PULSE_S;
              s_q     <= 1'b1;
              q_q     <= 1'b1;
            end
          end
        end
        PULSE_S, PULSE_R: begin
          if (pcnt_q == PW'(PULSE_CYCLES - 1)) begin
            state_q <= GAP;
            s_q     <= 1'b0;
            r_q     <= 1'b0;
          end else begin
            pcnt_q <= pcnt_q + PW'(1);
          end
        end
        GAP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign S        = s_q;
  assign R        = r_q;
  assign q_track  = q_q;
  assign busy     = busy_q;
  assign conflict = conflict_q;

endmodule
